wb_merge: RTL and testbench

- Write-back merge stage directly upstream of the register file write port (we/waddr/wdata).
- Merges two result sources into the single regfile write port:
  - the in-order pipeline result (ALU/CSR/jump), which cannot stall;
  - a long-latency result source (divider, load unit), which uses a valid/ready handshake.
- Late results wait in a small FIFO until the port is free.
- Exports a pending-register bitmap that the decode hazard logic uses.

---
 rtl/wb_merge_pkg.sv | 14 +
 rtl/wb_merge_if.sv | 41 ++++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/wb_merge.sv | 98 +++++++++
 tb/tb_wb_merge.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_merge_pkg.sv
// Shared types and constants for the write-back merge stage.
package wb_merge_pkg;

   // Register file geometry used by the rest of the core.
   typedef logic [4:0]  RegAddrBus;
   typedef logic [31:0] RegBus;

   localparam logic  WriteEnable = 1'b1;
   localparam RegBus ZeroWord    = 32'h0000_0000;

   // Default number of late results that can wait for the write port.
   localparam int WbDepth = 4;

endpackage

// File: rtl/wb_merge_if.sv
// Bus bundle of the write-back merge stage: pipeline source, long-latency
// source, and the register file write port with hazard information.
//
// Handshake (long-latency source): a result transfers on a clock edge where
// lat_valid_i and lat_ready_o are both high. The source must hold valid and its
// payload stable until that edge. lat_ready_o depends only on FIFO occupancy,
// never on lat_valid_i.
interface wb_merge_if import wb_merge_pkg::*; #(
   parameter int DEPTH = WbDepth,
   parameter int AW    = $bits(RegAddrBus),
   parameter int DW    = $bits(RegBus)
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic          pipe_we_i;
   logic [AW-1:0] pipe_waddr_i;
   logic [DW-1:0] pipe_wdata_i;
   logic          lat_valid_i;
   logic [AW-1:0] lat_waddr_i;
   logic [DW-1:0] lat_wdata_i;
   logic          lat_ready_o;
   logic          we_o;
   logic [AW-1:0] waddr_o;
   logic [DW-1:0] wdata_o;
   logic [31:0]   pend_o;
   logic [CW-1:0] count_o;

   // Upstream side: drives both result sources, observes the write port.
   modport master (
      output pipe_we_i, pipe_waddr_i, pipe_wdata_i,
      output lat_valid_i, lat_waddr_i, lat_wdata_i,
      input  lat_ready_o, we_o, waddr_o, wdata_o, pend_o, count_o
   );

   // The merge stage itself.
   modport slave (
      input  pipe_we_i, pipe_waddr_i, pipe_wdata_i,
      input  lat_valid_i, lat_waddr_i, lat_wdata_i,
      output lat_ready_o, we_o, waddr_o, wdata_o, pend_o, count_o
   );
endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO. Occupancy is kept in its own counter so full and
// empty never alias; the storage array and a per-slot valid mask are exported
// so the parent can derive hazard information from queued entries.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 37
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic [W-1:0]              din_i,
   input  logic                      pop_i,
   output logic [W-1:0]              dout_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic [DEPTH-1:0][W-1:0]   entries_o,
   output logic [DEPTH-1:0]          valid_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]            wr_ptr;
   logic [PW-1:0]            rd_ptr;
   logic [CW-1:0]            count;
   logic [DEPTH-1:0][W-1:0]  mem;
   logic                     do_push;
   logic                     do_pop;

   assign full_o    = (count == CW'(DEPTH));
   assign empty_o   = (count == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign dout_o    = mem[rd_ptr];
   assign count_o   = count;
   assign entries_o = mem;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: slots are only visible through valid_o.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din_i;
   end

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PW-1:0] off;
      off     = '0;
      valid_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = PW'(i) - rd_ptr;
         valid_o[i] = ({1'b0, off} < count);
      end
   end

endmodule

// File: rtl/wb_merge.sv
// Write-back merge stage: arbitrates the non-stallable pipeline result and the
// long-latency result stream onto the single register file write port. Late
// results that lose arbitration wait in wb_fifo; pend_o marks their targets.
module wb_merge import wb_merge_pkg::*; #(
   parameter int DEPTH = WbDepth,
   parameter int AW    = $bits(RegAddrBus),
   parameter int DW    = $bits(RegBus)
) (
   input logic       clk,
   input logic       rst,
   wb_merge_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = AW + DW;

   logic                    pipe_act;
   logic                    lat_nz;
   logic                    lat_acc;
   logic                    bypass;
   logic                    push;
   logic                    pop;
   logic                    full;
   logic                    empty;
   logic [EW-1:0]           head;
   logic [CW-1:0]           count;
   logic [DEPTH-1:0][EW-1:0] entries;
   logic [DEPTH-1:0]        valid;
   logic [31:0]             pend;

   logic                    we_q;
   logic [AW-1:0]           waddr_q;
   logic [DW-1:0]           wdata_q;

   wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push),
      .din_i     ({bus.lat_waddr_i, bus.lat_wdata_i}),
      .pop_i     (pop),
      .dout_o    (head),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (count),
      .entries_o (entries),
      .valid_o   (valid)
   );

   // Arbitration: pipe first, then FIFO head, then bypass of an incoming late
   // result. Writes to x0 never claim the port.
   always_comb begin
      pipe_act = bus.pipe_we_i && (bus.pipe_waddr_i != '0);
      lat_nz   = (bus.lat_waddr_i != '0);
      lat_acc  = bus.lat_valid_i && !full;
      pop      = !pipe_act && !empty;
      bypass   = !pipe_act && empty && bus.lat_valid_i && lat_nz;
      push     = lat_acc && lat_nz && !bypass;
   end

   // Registered write port; address/data hold when no source wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= DW'(ZeroWord);
      end else if (pipe_act) begin
         we_q    <= WriteEnable;
         waddr_q <= bus.pipe_waddr_i;
         wdata_q <= bus.pipe_wdata_i;
      end else if (pop) begin
         we_q    <= WriteEnable;
         waddr_q <= head[EW-1:DW];
         wdata_q <= head[DW-1:0];
      end else if (bypass) begin
         we_q    <= WriteEnable;
         waddr_q <= bus.lat_waddr_i;
         wdata_q <= bus.lat_wdata_i;
      end else begin
         we_q    <= 1'b0;
      end
   end

   // Pending bitmap over queued entries only; the head still counts while it
   // is being popped, and the output register is covered by regfile bypass.
   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i]) pend[entries[i][EW-1:DW]] = 1'b1;
      end
   end

   assign bus.lat_ready_o = !full;
   assign bus.we_o        = we_q;
   assign bus.waddr_o     = waddr_q;
   assign bus.wdata_o     = wdata_q;
   assign bus.pend_o      = pend;
   assign bus.count_o     = count;

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: reset, pipe-only writes, contention, fill and
// back-pressure, simultaneous push/pop, and reset while draining.
module tb_wb_merge;
   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic clk;
   logic rst;

   int n_chk  = 0;
   int n_fail = 0;

   logic [AW+DW-1:0] exp_q[$];

   wb_merge_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

   wb_merge #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pipe(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.pipe_we_i    = we;
      bus.pipe_waddr_i = a;
      bus.pipe_wdata_i = d;
   endtask

   task automatic drive_lat(input logic v, input logic [AW-1:0] a);
      bus.lat_valid_i = v;
      bus.lat_waddr_i = a;
      bus.lat_wdata_i = 32'h1000 + DW'(a);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
      chk({tag, ".we"}, 64'(bus.we_o), 64'd1);
      chk({tag, ".waddr"}, 64'(bus.waddr_o), 64'(a));
      chk({tag, ".wdata"}, 64'(bus.wdata_o), 64'(d));
   endtask

   task automatic chk_drain(input string tag);
      logic [AW+DW-1:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, ".queue_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".we"}, 64'(bus.we_o), 64'd1);
         chk({tag, ".entry"}, 64'({bus.waddr_o, bus.wdata_o}), 64'(e));
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_pipe(1'b0, '0, '0);
      drive_lat(1'b0, '0);

      // 1. Reset with a late result waiting, then bypass on release.
      drive_lat(1'b1, 5'd9);
      step();
      step();
      chk("rst.we",    64'(bus.we_o), 64'd0);
      chk("rst.waddr", 64'(bus.waddr_o), 64'd0);
      chk("rst.wdata", 64'(bus.wdata_o), 64'd0);
      chk("rst.ready", 64'(bus.lat_ready_o), 64'd1);
      chk("rst.count", 64'(bus.count_o), 64'd0);
      chk("rst.pend",  64'(bus.pend_o), 64'd0);
      rst = 1'b0;
      step();
      chk_wr("bypass", 5'd9, 32'h1009);
      chk("bypass.count", 64'(bus.count_o), 64'd0);
      drive_lat(1'b0, '0);
      step();
      chk("idle.we",    64'(bus.we_o), 64'd0);
      chk("idle.waddr", 64'(bus.waddr_o), 64'd9);

      // 2. Pipe only, then a pipe write to x0 that must not reach the port.
      drive_pipe(1'b1, 5'd5, 32'h1234);
      step();
      chk_wr("pipe5", 5'd5, 32'h1234);
      drive_pipe(1'b1, 5'd0, 32'hFFFF);
      step();
      chk("pipe_x0.we",    64'(bus.we_o), 64'd0);
      chk("pipe_x0.waddr", 64'(bus.waddr_o), 64'd5);
      chk("pipe_x0.wdata", 64'(bus.wdata_o), 64'h1234);
      drive_pipe(1'b0, '0, '0);

      // 3. Contention: pipe wins, late result queued and drained next.
      drive_pipe(1'b1, 5'd3, 32'hA);
      bus.lat_valid_i = 1'b1;
      bus.lat_waddr_i = 5'd7;
      bus.lat_wdata_i = 32'hB;
      step();
      chk_wr("cont.pipe", 5'd3, 32'hA);
      chk("cont.count", 64'(bus.count_o), 64'd1);
      chk("cont.pend",  64'(bus.pend_o), 64'h80);
      drive_pipe(1'b0, '0, '0);
      drive_lat(1'b0, '0);
      #1;
      chk("cont.pend_popping", 64'(bus.pend_o), 64'h80);
      step();
      chk_wr("cont.late", 5'd7, 32'hB);
      chk("cont.count0", 64'(bus.count_o), 64'd0);
      chk("cont.pend0",  64'(bus.pend_o), 64'd0);
      step();
      chk("cont.idle_we", 64'(bus.we_o), 64'd0);

      // 4. Fill behind a continuous pipe stream, back-pressure, in-order drain.
      for (int i = 0; i < 4; i++) begin
         drive_pipe(1'b1, 5'd1, 32'h100 + i);
         drive_lat(1'b1, 5'(10 + i));
         exp_q.push_back({5'(10 + i), 32'h1000 + 32'(10 + i)});
         step();
         chk("fill.pipe_waddr", 64'(bus.waddr_o), 64'd1);
         chk("fill.pipe_wdata", 64'(bus.wdata_o), 64'(32'h100 + i));
      end
      chk("full.count", 64'(bus.count_o), 64'd4);
      chk("full.ready", 64'(bus.lat_ready_o), 64'd0);
      chk("full.pend",  64'(bus.pend_o), 64'h3C00);
      drive_lat(1'b1, 5'd14);
      exp_q.push_back({5'd14, 32'h100E});
      step();
      step();
      chk("held.count", 64'(bus.count_o), 64'd4);
      chk("held.ready", 64'(bus.lat_ready_o), 64'd0);
      chk("held.pend",  64'(bus.pend_o), 64'h3C00);
      drive_pipe(1'b0, '0, '0);
      step();
      chk_drain("drain10");
      chk("drain10.count", 64'(bus.count_o), 64'd3);
      chk("drain10.ready", 64'(bus.lat_ready_o), 64'd1);
      step();
      chk_drain("drain11");
      chk("drain11.count", 64'(bus.count_o), 64'd3);
      chk("drain11.pend",  64'(bus.pend_o), 64'h7000);
      drive_lat(1'b0, '0);
      step();
      chk_drain("drain12");
      step();
      chk_drain("drain13");
      step();
      chk_drain("drain14");
      chk("drain.count0", 64'(bus.count_o), 64'd0);
      chk("drain.pend0",  64'(bus.pend_o), 64'd0);
      step();
      chk("drain.idle_we", 64'(bus.we_o), 64'd0);

      // 5. Simultaneous push and pop with two entries queued.
      drive_pipe(1'b1, 5'd2, 32'h22);
      drive_lat(1'b1, 5'd21);
      exp_q.push_back({5'd21, 32'h1015});
      step();
      drive_lat(1'b1, 5'd22);
      exp_q.push_back({5'd22, 32'h1016});
      step();
      chk("pp.count_pre", 64'(bus.count_o), 64'd2);
      drive_pipe(1'b0, '0, '0);
      drive_lat(1'b1, 5'd20);
      exp_q.push_back({5'd20, 32'h1014});
      step();
      chk_drain("pp.pop21");
      chk("pp.count", 64'(bus.count_o), 64'd2);
      chk("pp.pend",  64'(bus.pend_o), 64'h0050_0000);
      drive_lat(1'b0, '0);
      step();
      chk_drain("pp.pop22");
      step();
      chk_drain("pp.pop20");
      chk("pp.count0", 64'(bus.count_o), 64'd0);

      // 6. Reset while draining discards queued results.
      for (int i = 0; i < 4; i++) begin
         drive_pipe(1'b1, 5'd4, 32'h44);
         drive_lat(1'b1, 5'(25 + i));
         step();
      end
      chk("rd.count4", 64'(bus.count_o), 64'd4);
      drive_pipe(1'b0, '0, '0);
      drive_lat(1'b0, '0);
      step();
      chk_wr("rd.pop25", 5'd25, 32'h1019);
      chk("rd.count3", 64'(bus.count_o), 64'd3);
      rst = 1'b1;
      step();
      chk("rd.we",    64'(bus.we_o), 64'd0);
      chk("rd.waddr", 64'(bus.waddr_o), 64'd0);
      chk("rd.count", 64'(bus.count_o), 64'd0);
      chk("rd.pend",  64'(bus.pend_o), 64'd0);
      chk("rd.ready", 64'(bus.lat_ready_o), 64'd1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rd.after_we", 64'(bus.we_o), 64'd0);
         chk("rd.after_count", 64'(bus.count_o), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
